// File: rtl/rom_banked.sv
// ---------------------------------------------------------------------------
// rom_banked
//
// Banked program ROM with a registered read pipeline and a runtime download
// port. The address space is BANKS banks of 2^BANK_AW words each. The upper
// address bits select the bank and the lower BANK_AW bits are the offset.
// Reads take LATENCY (1 or 2) cycles. A bank that has not been loaded
// answers with FILL and err. A download session (dl_en) clears the loaded
// mask and then rewrites words. Writing the last word of a bank marks that
// bank as loaded.
//
// Ports
//   clk      in   1      system clock
//   rst      in   1      asynchronous active-high reset
//   cs       in   1      read request (one per cycle)
//   addr     in   AW     read address, upper bits = bank
//   data     out  DW     read data (holds last value when valid = 0)
//   valid    out  1      data is the result of a request LATENCY cycles ago
//   err      out  1      with valid: request hit an unloaded bank
//   dl_en    in   1      download session active
//   dl_we    in   1      download write strobe
//   dl_addr  in   AW     download address
//   dl_data  in   DW     download data
//   loaded   out  BANKS  per-bank loaded mask
//   busy     out  1      download state machine is in LOAD
// ---------------------------------------------------------------------------
module rom_banked #(
    parameter int unsigned      BANKS       = 2,
    parameter int unsigned      BANK_AW     = 11,
    parameter int unsigned      DW          = 8,
    parameter int unsigned      LATENCY     = 1,
    parameter logic [DW-1:0]    FILL        = DW'(8'hFF),
    parameter logic [BANKS-1:0] INIT_LOADED = '1,
    localparam int unsigned     BW          = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int unsigned     AW          = BANK_AW + $clog2(BANKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic [AW-1:0]    addr,
    output logic [DW-1:0]    data,
    output logic             valid,
    output logic             err,
    input  logic             dl_en,
    input  logic             dl_we,
    input  logic [AW-1:0]    dl_addr,
    input  logic [DW-1:0]    dl_data,
    output logic [BANKS-1:0] loaded,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    state_e                   state_q;
    logic                     dl_en_q;
    logic [BANKS-1:0]         loaded_q;

    logic [BW-1:0]            rd_bank;
    logic [BW-1:0]            wr_bank;
    logic [BANK_AW-1:0]       rd_off;
    logic [BANK_AW-1:0]       wr_off;
    logic [BANKS-1:0]         rd_sel_oh;
    logic [BANKS-1:0]         wr_sel_oh;
    logic                     dl_rise;
    logic                     rd_acc;
    logic                     wr_acc;
    logic                     rd_loaded;

    logic [BANKS-1:0][DW-1:0] rd_all;

    logic                     s1_vld_q;
    logic                     s1_ld_q;
    logic [BW-1:0]            s1_bank_q;
    logic [DW-1:0]            s1_data;
    logic                     s1_err;

    logic                     out_vld;
    logic [DW-1:0]            out_data;
    logic                     out_err;
    logic [DW-1:0]            hold_q;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    // The shift also covers BANKS = 1, where there are no bank bits at all.
    assign rd_bank = BW'(addr >> BANK_AW);
    assign wr_bank = BW'(dl_addr >> BANK_AW);
    assign rd_off  = addr[BANK_AW-1:0];
    assign wr_off  = dl_addr[BANK_AW-1:0];

    always_comb begin
        rd_sel_oh = '0;
        wr_sel_oh = '0;
        for (int unsigned i = 0; i < BANKS; i++) begin
            rd_sel_oh[i] = (rd_bank == BW'(i));
            wr_sel_oh[i] = (wr_bank == BW'(i));
        end
    end

    assign rd_loaded = |(loaded_q & rd_sel_oh);

    // A rising dl_en seen in IDLE starts a download session. A request made
    // in that same cycle is dropped.
    assign dl_rise = (state_q == IDLE) && dl_en && !dl_en_q;
    assign rd_acc  = (state_q == IDLE) && cs && !dl_rise;
    assign wr_acc  = (state_q == LOAD) && dl_we;

    // -----------------------------------------------------------------------
    // Bank storage: synchronous read and write, enabled per bank, no reset
    // -----------------------------------------------------------------------
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DW-1:0] mem_q [2**BANK_AW];
        logic [DW-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_acc && wr_sel_oh[b]) begin
                mem_q[wr_off] <= dl_data;
            end
            if (rd_acc && rd_sel_oh[b]) begin
                rd_q <= mem_q[rd_off];
            end
        end

        assign rd_all[b] = rd_q;
    end

    // -----------------------------------------------------------------------
    // Download state machine and loaded mask
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dl_en_q  <= 1'b0;
            loaded_q <= INIT_LOADED;
        end else begin
            dl_en_q <= dl_en;
            case (state_q)
                IDLE: begin
                    if (dl_rise) begin
                        state_q  <= LOAD;
                        loaded_q <= '0;
                    end
                end
                LOAD: begin
                    // Writing the last word of a bank completes that bank.
                    if (wr_acc && (&wr_off)) begin
                        loaded_q <= loaded_q | wr_sel_oh;
                    end
                    if (!dl_en) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Read pipeline stage 1: request tag travels with the memory read
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_ld_q   <= 1'b0;
            s1_bank_q <= '0;
        end else begin
            s1_vld_q <= rd_acc;
            if (rd_acc) begin
                s1_bank_q <= rd_bank;
                s1_ld_q   <= rd_loaded;
            end
        end
    end

    // The mux uses the registered bank index, so the current addr does not
    // affect the result.
    always_comb begin
        s1_data = FILL;
        if (s1_ld_q) begin
            for (int unsigned i = 0; i < BANKS; i++) begin
                if (s1_bank_q == BW'(i)) begin
                    s1_data = rd_all[i];
                end
            end
        end
    end

    assign s1_err = !s1_ld_q;

    // -----------------------------------------------------------------------
    // Optional second output stage
    // -----------------------------------------------------------------------
    if (LATENCY == 2) begin : g_lat2
        logic          s2_vld_q;
        logic [DW-1:0] s2_data_q;
        logic          s2_err_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_vld_q  <= 1'b0;
                s2_data_q <= '0;
                s2_err_q  <= 1'b0;
            end else begin
                s2_vld_q <= s1_vld_q && !dl_rise;
                if (s1_vld_q) begin
                    s2_data_q <= s1_data;
                    s2_err_q  <= s1_err;
                end
            end
        end

        assign out_vld  = s2_vld_q;
        assign out_data = s2_data_q;
        assign out_err  = s2_err_q;
    end else begin : g_lat1
        assign out_vld  = s1_vld_q;
        assign out_data = s1_data;
        assign out_err  = s1_err;
    end

    // -----------------------------------------------------------------------
    // Output: the result that reaches the output in the cycle a session
    // starts is suppressed. data holds the last delivered word whenever
    // valid is low.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (valid) begin
            hold_q <= out_data;
        end
    end

    assign valid  = out_vld && !dl_rise;
    assign err    = valid && out_err;
    assign data   = valid ? out_data : hold_q;
    assign loaded = loaded_q;
    assign busy   = (state_q == LOAD);

endmodule

// File: tb/tb_rom_banked.sv
// ---------------------------------------------------------------------------
// tb_rom_banked
//
// Two instances share one input bus. A is BANKS=2, BANK_AW=11, LATENCY=1.
// B is BANKS=4, BANK_AW=10, LATENCY=2. Both cover the same 4096-word space.
// A transaction-level model keeps the image, the per-bank loaded masks and
// a queue of due responses for each instance. A monitor compares every
// cycle, and directed sequences and a vector table cover the corner cases.
// ---------------------------------------------------------------------------
module tb_rom_banked;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic [11:0] addr;
    logic        dl_en;
    logic        dl_we;
    logic [11:0] dl_addr;
    logic [7:0]  dl_data;

    logic [7:0]  data_a, data_b;
    logic        valid_a, valid_b, err_a, err_b, busy_a, busy_b;
    logic [1:0]  loaded_a;
    logic [3:0]  loaded_b;

    always #5 clk = ~clk;

    rom_banked #(
        .BANKS(2), .BANK_AW(11), .DW(8), .LATENCY(1),
        .FILL(8'hFF), .INIT_LOADED(2'b11)
    ) u_a (
        .clk(clk), .rst(rst), .cs(cs), .addr(addr),
        .data(data_a), .valid(valid_a), .err(err_a),
        .dl_en(dl_en), .dl_we(dl_we), .dl_addr(dl_addr), .dl_data(dl_data),
        .loaded(loaded_a), .busy(busy_a)
    );

    rom_banked #(
        .BANKS(4), .BANK_AW(10), .DW(8), .LATENCY(2),
        .FILL(8'hFF), .INIT_LOADED(4'b1111)
    ) u_b (
        .clk(clk), .rst(rst), .cs(cs), .addr(addr),
        .data(data_b), .valid(valid_b), .err(err_b),
        .dl_en(dl_en), .dl_we(dl_we), .dl_addr(dl_addr), .dl_data(dl_data),
        .loaded(loaded_b), .busy(busy_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        logic [7:0] data;
        logic       err;
    } exp_t;

    typedef struct {
        logic       c;
        logic [11:0] a;
        logic [7:0] ed;
    } vec_t;

    logic [7:0] mem [4096];
    logic [1:0] ld_a;
    logic [3:0] ld_b;
    logic       in_load;
    logic       prev_en;
    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [7:0] last_a, last_b;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic       mon_en = 1'b0;

    vec_t        tbl [8];
    logic [11:0] tv_a [8];
    logic        tv_c [8];
    logic [7:0]  hv;
    logic        en_r;
    logic [11:0] wa;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        last_a  = 8'h00;
        last_b  = 8'h00;
        ld_a    = 2'b11;
        ld_b    = 4'b1111;
        in_load = 1'b0;
        prev_en = 1'b0;
    endtask

    // Drive one cycle's inputs and advance the model to match.
    task automatic apply(input logic c, input logic [11:0] a, input logic en,
                         input logic we, input logic [11:0] wad, input logic [7:0] wd);
        exp_t e;
        logic nxt;
        cs = c; addr = a; dl_en = en; dl_we = we; dl_addr = wad; dl_data = wd;
        nxt = in_load;
        if (!in_load) begin
            if (en && !prev_en) begin
                q_a.delete();
                q_b.delete();
                ld_a = '0;
                ld_b = '0;
                nxt  = 1'b1;
            end else if (c) begin
                e.due  = cyc + 1;
                e.err  = !ld_a[int'(a) / 2048];
                e.data = e.err ? 8'hFF : mem[a];
                q_a.push_back(e);
                e.due  = cyc + 2;
                e.err  = !ld_b[int'(a) / 1024];
                e.data = e.err ? 8'hFF : mem[a];
                q_b.push_back(e);
            end
        end else begin
            if (we) begin
                mem[wad] = wd;
                if (int'(wad) % 2048 == 2047) ld_a[int'(wad) / 2048] = 1'b1;
                if (int'(wad) % 1024 == 1023) ld_b[int'(wad) / 1024] = 1'b1;
            end
            if (!en) nxt = 1'b0;
        end
        prev_en = en;
        in_load = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic [11:0] a, input logic en,
                         input logic we, input logic [11:0] wad, input logic [7:0] wd);
        apply(c, a, en, we, wad, wd);
        tick();
    endtask

    // ---------------- per-cycle monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (q_a.size() > 0 && q_a[0].due == cyc) begin
                e = q_a.pop_front();
                check("mon.a.valid", valid_a, 1);
                check("mon.a.data", data_a, e.data);
                check("mon.a.err", err_a, e.err);
                last_a = e.data;
            end else begin
                check("mon.a.valid_idle", valid_a, 0);
                check("mon.a.hold", data_a, last_a);
                check("mon.a.err_idle", err_a, 0);
            end
            if (q_b.size() > 0 && q_b[0].due == cyc) begin
                e = q_b.pop_front();
                check("mon.b.valid", valid_b, 1);
                check("mon.b.data", data_b, e.data);
                check("mon.b.err", err_b, e.err);
                last_b = e.data;
            end else begin
                check("mon.b.valid_idle", valid_b, 0);
                check("mon.b.hold", data_b, last_b);
                check("mon.b.err_idle", err_b, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1; cs = 1'b0; addr = '0; dl_en = 1'b0; dl_we = 1'b0;
        dl_addr = '0; dl_data = '0;
        en_r = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid_a", valid_a, 0);
        check("rst.data_a", data_a, 0);
        check("rst.err_a", err_a, 0);
        check("rst.busy_a", busy_a, 0);
        check("rst.loaded_a", loaded_a, 2'b11);
        check("rst.valid_b", valid_b, 0);
        check("rst.loaded_b", loaded_b, 4'b1111);
        rst = 1'b0;
        mon_en = 1'b1;

        // Full random image into both instances.
        drive(0, 0, 1, 0, 0, 0);
        check("dl.busy_a", busy_a, 1);
        check("dl.busy_b", busy_b, 1);
        check("dl.loaded_a_clr", loaded_a, 0);
        check("dl.loaded_b_clr", loaded_b, 0);
        for (int i = 0; i < 4096; i++) drive(0, 0, 1, 1, 12'(i), 8'($urandom));
        drive(0, 0, 0, 0, 0, 0);
        check("dl.busy_a_end", busy_a, 0);
        check("dl.loaded_a_full", loaded_a, 2'b11);
        check("dl.loaded_b_full", loaded_b, 4'b1111);

        // Vector table: back-to-back reads, bank switch, registered bank select.
        tv_a = '{12'h000, 12'h800, 12'h7FF, 12'h800, 12'hC05, 12'hC05, 12'h3FF, 12'h000};
        tv_c = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        hv = last_a;
        for (int i = 0; i < 8; i++) begin
            tbl[i].c = tv_c[i];
            tbl[i].a = tv_a[i];
            if (tv_c[i]) hv = mem[tv_a[i]];
            tbl[i].ed = hv;
        end
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].c, tbl[i].a, 0, 0, 0, 0);
            check("tbl.a.valid", valid_a, tbl[i].c);
            check("tbl.a.data", data_a, tbl[i].ed);
            check("tbl.a.err", err_a, 0);
            if (i > 0) begin
                check("tbl.b.valid", valid_b, tbl[i-1].c);
                check("tbl.b.data", data_b, tbl[i-1].ed);
            end
        end
        drive(0, 0, 0, 0, 0, 0);

        // Latency-2 request at 0xC05 (bank 3 of B).
        drive(1, 12'hC05, 0, 0, 0, 0);
        check("lat2.b.cycle1", valid_b, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("lat2.b.cycle2", valid_b, 1);
        check("lat2.b.data", data_b, mem[12'hC05]);
        drive(0, 0, 0, 0, 0, 0);
        check("lat2.b.cycle3", valid_b, 0);

        // Random reads on a fully loaded image.
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 3) != 0), 12'($urandom), 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0);

        // Partial download: bank 0 of A (banks 0,1 of B) to 0xA5.
        drive(0, 0, 1, 0, 0, 0);
        check("a5.busy_a", busy_a, 1);
        check("a5.loaded_a_clr", loaded_a, 0);
        for (int i = 0; i < 2048; i++) drive(0, 0, 1, 1, 12'(i), 8'hA5);
        drive(0, 0, 0, 0, 0, 0);
        check("a5.loaded_a", loaded_a, 2'b01);
        check("a5.loaded_b", loaded_b, 4'b0011);
        drive(1, 12'h123, 0, 0, 0, 0);
        check("a5.rd123.valid", valid_a, 1);
        check("a5.rd123.data", data_a, 8'hA5);
        check("a5.rd123.err", err_a, 0);
        drive(1, 12'h923, 0, 0, 0, 0);
        check("a5.rd923.valid", valid_a, 1);
        check("a5.rd923.data", data_a, 8'hFF);
        check("a5.rd923.err", err_a, 1);
        repeat (3) drive(0, 0, 0, 0, 0, 0);

        // Flush: request followed by a dl_en rising edge.
        drive(1, 12'h010, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0);
        #1;
        check("flush.valid_a", valid_a, 0);
        check("flush.err_a", err_a, 0);
        tick();
        check("flush.valid_b", valid_b, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 12'($urandom), 1, 0, 0, 0);
            check("load.cs.valid_a", valid_a, 0);
            check("load.cs.valid_b", valid_b, 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 12'h400, 0, 0, 0, 0);
        check("unl.err_a", err_a, 1);
        check("unl.data_a", data_a, 8'hFF);
        repeat (3) drive(0, 0, 0, 0, 0, 0);

        // Reset mid-download after 100 words of bank 0.
        drive(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 100; i++) drive(0, 0, 1, 1, 12'(i), 8'($urandom));
        #2;
        rst = 1'b1;
        cs = 1'b0; dl_en = 1'b0; dl_we = 1'b0;
        model_reset();
        #1;
        check("mrst.valid_a", valid_a, 0);
        check("mrst.data_a", data_a, 0);
        check("mrst.err_a", err_a, 0);
        check("mrst.busy_a", busy_a, 0);
        check("mrst.loaded_a", loaded_a, 2'b11);
        check("mrst.busy_b", busy_b, 0);
        check("mrst.loaded_b", loaded_b, 4'b1111);
        tick();
        rst = 1'b0;
        drive(1, 12'h010, 0, 0, 0, 0);
        check("mrst.rd.valid", valid_a, 1);
        check("mrst.rd.data", data_a, mem[12'h010]);
        repeat (3) drive(0, 0, 0, 0, 0, 0);

        // Random mix of reads and short download sessions.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) en_r = !en_r;
            wa = 12'($urandom);
            if ($urandom_range(0, 7) == 0) wa[9:0] = '1;
            drive(1'($urandom), 12'($urandom), en_r, 1'($urandom), wa, 8'($urandom));
        end
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) drive(1'($urandom), 12'($urandom), 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
